// File: rtl/core_states_pkg.sv
// Core pipeline state encoding shared by the per-core units.
// The scheduler drives this state to every unit in the core.
package core_states_pkg;
    typedef enum logic [2:0] {
        CORE_IDLE = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        REQUEST   = 3'd3,
        WAIT      = 3'd4,
        EXECUTE   = 3'd5,
        UPDATE    = 3'd6,
        CORE_DONE = 3'd7
    } core_state_e;
endpackage

// File: rtl/regfile_pkg.sv
// Register-file writeback types: result source select and read-only register window.
package regfile_pkg;
    typedef enum logic [1:0] {
        ARITHMETIC = 2'd0,
        MEMORY     = 2'd1,
        CONSTANT   = 2'd2
    } wb_src_e;

    localparam logic [3:0] RO_REG_BASE = 4'd13;

    // Registers 13..15 are read-only and source 2'b11 is undefined.
    function automatic logic wb_write_legal(input logic [3:0] rd, input logic [1:0] src);
        return (rd < RO_REG_BASE) && (src != 2'b11);
    endfunction
endpackage

// File: rtl/wb_result_slot.sv
// One thread lane's captured writeback result: a valid bit plus data.
// Exposes next-state values so a commit can include a result arriving this cycle.
module wb_result_slot
    import regfile_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic                 clear_valid_i,
    input  logic                 capture_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 valid_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_d_o,
    output logic [DATA_BITS-1:0] data_d_o
);
    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = clear_valid_i;
        end else if (capture_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (enable_i) begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign valid_d_o = valid_d;
    assign data_d_o  = data_d;
endmodule

// File: rtl/regfile_writeback.sv
// Per-core writeback unit: collects per-thread results and commits one registered write burst.
// Optional WB_ERR_CHECK_EN adds a sticky wb_err flag for writes to read-only regs or undefined sources.
module regfile_writeback
    import core_states_pkg::*;
    import regfile_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int DATA_BITS         = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic [2:0]                             core_state,
    input  logic [THREADS_PER_BLOCK-1:0]           thread_mask,
    input  logic                                   decoded_reg_write_enable,
    input  logic [1:0]                             decoded_reg_input_mux,
    input  logic [3:0]                             decoded_rd_address,
    input  logic [DATA_BITS-1:0]                   decoded_immediate,
    input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] alu_out,
    input  logic [THREADS_PER_BLOCK-1:0]           lsu_resp_valid,
    input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] lsu_resp_data,
    output logic [THREADS_PER_BLOCK-1:0]           wb_we,
    output logic [3:0]                             wb_addr,
    output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] wb_data,
    output logic                                   wb_pending,
    output logic                                   wb_done,
    output logic                                   wb_err
);
    localparam int T  = THREADS_PER_BLOCK;
    localparam int DB = DATA_BITS;

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, COMMIT = 2'd2} wb_state_e;

    core_state_e cs;
    assign cs = core_state_e'(core_state);

    wb_state_e       state_q, state_d;
    logic [3:0]      rd_q, rd_d;
    logic [1:0]      mux_q, mux_d;
    logic            we_q, we_d;
    logic [T-1:0]    target_q, target_d;
    logic            exec_seen_q, exec_seen_d;
    logic            update_seen_q, update_seen_d;

    logic [T-1:0]    wb_we_q, wb_we_d;
    logic [3:0]      wb_addr_q, wb_addr_d;
    logic [T*DB-1:0] wb_data_q, wb_data_d;
    logic            wb_done_q, wb_done_d;

    logic [T-1:0]    valid_vec, valid_d_vec, capture_vec;
    logic [T*DB-1:0] data_vec, data_d_vec, lane_in_vec;

    logic start, first_exec, all_ready, commit_go, legal, clear_valid;

    assign start      = (state_q == IDLE) && (cs == REQUEST);
    // ALU and immediate results are only sampled on the first EXECUTE cycle of the instruction.
    assign first_exec = (state_q == COLLECT) && (cs == EXECUTE) && !exec_seen_q
                        && ((mux_q == ARITHMETIC) || (mux_q == CONSTANT));
    // Nothing will ever arrive for non-writing or undefined-source instructions.
    assign clear_valid = !decoded_reg_write_enable || (decoded_reg_input_mux == 2'b11);
    assign all_ready  = ((target_q & ~valid_d_vec) == '0);
    assign commit_go  = (state_q == COLLECT) && ((cs == UPDATE) || update_seen_q) && all_ready;
    assign legal      = wb_write_legal(rd_q, mux_q);

    generate
        for (genvar gi = 0; gi < T; gi++) begin : g_lane
            assign lane_in_vec[gi*DB +: DB] = (mux_q == MEMORY)   ? lsu_resp_data[gi*DB +: DB] :
                                              (mux_q == CONSTANT) ? decoded_immediate :
                                                                    alu_out[gi*DB +: DB];
            assign capture_vec[gi] = (state_q == COLLECT) && target_q[gi] && we_q
                                     && ((mux_q == MEMORY) ? lsu_resp_valid[gi] : first_exec);

            wb_result_slot #(.DATA_BITS(DB)) u_slot (
                .clk           (clk),
                .reset         (reset),
                .enable_i      (enable),
                .clear_i       (start),
                .clear_valid_i (clear_valid),
                .capture_i     (capture_vec[gi]),
                .data_i        (lane_in_vec[gi*DB +: DB]),
                .valid_o       (valid_vec[gi]),
                .data_o        (data_vec[gi*DB +: DB]),
                .valid_d_o     (valid_d_vec[gi]),
                .data_d_o      (data_d_vec[gi*DB +: DB])
            );
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        rd_d          = rd_q;
        mux_d         = mux_q;
        we_d          = we_q;
        target_d      = target_q;
        exec_seen_d   = exec_seen_q;
        update_seen_d = update_seen_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = COLLECT;
                    rd_d          = decoded_rd_address;
                    mux_d         = decoded_reg_input_mux;
                    we_d          = decoded_reg_write_enable;
                    target_d      = thread_mask;
                    exec_seen_d   = 1'b0;
                    update_seen_d = 1'b0;
                end
            end
            COLLECT: begin
                if (cs == EXECUTE) exec_seen_d = 1'b1;
                if (cs == UPDATE)  update_seen_d = 1'b1;
                if (commit_go)     state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_we_d   = '0;
        wb_done_d = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (commit_go) begin
            wb_done_d = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = data_d_vec;
            if (we_q && legal) wb_we_d = target_q & valid_d_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rd_q          <= '0;
            mux_q         <= '0;
            we_q          <= 1'b0;
            target_q      <= '0;
            exec_seen_q   <= 1'b0;
            update_seen_q <= 1'b0;
            wb_we_q       <= '0;
            wb_addr_q     <= '0;
            wb_data_q     <= '0;
            wb_done_q     <= 1'b0;
        end else if (enable) begin
            state_q       <= state_d;
            rd_q          <= rd_d;
            mux_q         <= mux_d;
            we_q          <= we_d;
            target_q      <= target_d;
            exec_seen_q   <= exec_seen_d;
            update_seen_q <= update_seen_d;
            wb_we_q       <= wb_we_d;
            wb_addr_q     <= wb_addr_d;
            wb_data_q     <= wb_data_d;
            wb_done_q     <= wb_done_d;
        end
    end

`ifdef WB_ERR_CHECK_EN
    logic wb_err_q;
    logic err_set;
    assign err_set = commit_go && we_q && !legal;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_err_q <= 1'b0;
        end else if (enable && err_set) begin
            wb_err_q <= 1'b1;
        end
    end
    assign wb_err = wb_err_q;
`else
    assign wb_err = 1'b0;
`endif

    assign wb_pending = (state_q == COLLECT) && ((target_q & ~valid_vec) != '0);
    assign wb_we      = wb_we_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign wb_done    = wb_done_q;
endmodule
